pwm_duty_sequencer: RTL and testbench

Generalised duty-cycle controller for the PWM channel bank. It drives the duty register write port (we/ch_sel/duty_in) for NUM_CH channels of DUTY_W bits, in one of three modes: MANUAL, STEP and SWEEP. Button inputs are synchronised and debounced on chip. A per-channel shadow copy of the last written duty provides read-modify-write stepping.

---
 rtl/pwm_duty_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// ----------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Duty-cycle controller for the PWM channel bank. Drives the duty register
// write port (we / ch_sel / duty_in) in one of three modes:
//   MANUAL - direct writes from the man_* port
//   STEP   - each step-button press bumps the next channel by STEP
//   SWEEP  - a timed triangle ramp written round-robin to all channels
// The two buttons are synchronised and debounced here. A shadow copy of the
// last value written to each channel supports read-modify-write stepping.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous reset, active high
//   btn_mode  in   raw mode button (asynchronous, bouncy)
//   btn_step  in   raw step button (asynchronous, bouncy)
//   man_ch    in   manual write channel
//   man_val   in   manual write value
//   man_wr    in   single-cycle manual write strobe
//   we        out  duty register write enable, one-cycle pulse
//   ch_sel    out  channel of the write (holds when we=0)
//   duty_in   out  duty value of the write (holds when we=0)
//   mode      out  current mode: 0=MANUAL, 1=STEP, 2=SWEEP
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// pwm_btn_debounce
//
// Two-flop synchroniser followed by a stability counter. The debounced level
// only changes after DEB_CYCLES consecutive synced samples disagree with it;
// a rising debounced edge produces a registered one-cycle press pulse.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous reset, active high
//   raw    in   raw button level
//   press  out  one-cycle pulse on an accepted 0->1 transition
// ----------------------------------------------------------------------------
module pwm_btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b != level) begin
                // This sample is the DEB_CYCLES-th disagreeing one in a row.
                if (cnt == CNT_LAST) begin
                    level <= sync_b;
                    cnt   <= '0;
                    press <= sync_b;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// ----------------------------------------------------------------------------
// Mode FSM
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   MODE_MANUAL  | man_wr writes man_val to man_ch (if in range)
//   MODE_STEP    | step press writes shadow[next ch] + STEP (wrapping)
//   MODE_SWEEP   | every SWEEP_DIV cycles write the ramp to the next channel
//
// A mode press advances MANUAL -> STEP -> SWEEP -> MANUAL; whatever action
// is due in that cycle is still taken under the old mode.
// ----------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int DUTY_W     = 8,
    parameter int STEP       = 32,
    parameter int DEB_CYCLES = 4,
    parameter int SWEEP_DIV  = 16,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_step,
    input  logic [CH_W-1:0]   man_ch,
    input  logic [DUTY_W-1:0] man_val,
    input  logic              man_wr,
    output logic              we,
    output logic [CH_W-1:0]   ch_sel,
    output logic [DUTY_W-1:0] duty_in,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_SWEEP  = 2'd2
    } mode_t;

    localparam int                CHX_W     = CH_W + 1;
    localparam int                DUTYX_W   = DUTY_W + 1;
    localparam int                TICK_W    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CHX_W-1:0]  NUM_CH_X  = CHX_W'(NUM_CH);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTYX_W-1:0] STEP_X   = DUTYX_W'(STEP);
    localparam logic [DUTYX_W-1:0] DUTY_MAX_X = {1'b0, {DUTY_W{1'b1}}};
    // The sweep timer is a down-counter: loading SWEEP_DIV-1 corresponds to
    // "no cycles elapsed", and the write fires when it reaches zero.
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(SWEEP_DIV - 1);

    mode_t               state;
    mode_t               state_next;

    logic                mode_press;
    logic                step_press;

    logic [DUTY_W-1:0]   shadow [NUM_CH];

    logic [CH_W-1:0]     ptr;
    logic [DUTY_W-1:0]   ramp;
    logic                dir_down;
    logic [TICK_W-1:0]   tick;

    logic                we_next;
    logic [CH_W-1:0]     ch_next;
    logic [DUTY_W-1:0]   duty_next;
    logic [CH_W-1:0]     ptr_next;
    logic [DUTY_W-1:0]   ramp_next;
    logic                dir_next;
    logic [TICK_W-1:0]   tick_next;

    logic [CH_W-1:0]     step_ch;
    logic [CH_W-1:0]     ptr_inc;
    logic [DUTYX_W-1:0]  ramp_up;

    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode),
        .press (mode_press)
    );

    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .press (step_press)
    );

    assign mode = state;

    // Step target follows the last written channel, whoever wrote it.
    assign step_ch = (ch_sel == LAST_CH) ? '0 : ch_sel + CH_W'(1);
    assign ptr_inc = (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
    // One extra bit so an up-step past full scale is detected, not wrapped.
    assign ramp_up = {1'b0, ramp} + STEP_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MODE_STEP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we_next    = 1'b0;
        ch_next    = ch_sel;
        duty_next  = duty_in;
        ptr_next   = ptr;
        ramp_next  = ramp;
        dir_next   = dir_down;
        tick_next  = tick;

        case (state)
            MODE_MANUAL: begin
                if (man_wr && ({1'b0, man_ch} < NUM_CH_X)) begin
                    we_next   = 1'b1;
                    ch_next   = man_ch;
                    duty_next = man_val;
                end
            end
            MODE_STEP: begin
                if (step_press) begin
                    we_next   = 1'b1;
                    ch_next   = step_ch;
                    duty_next = shadow[step_ch] + STEP_D;
                end
            end
            MODE_SWEEP: begin
                if (tick == '0) begin
                    tick_next = TICK_LOAD;
                    we_next   = 1'b1;
                    ch_next   = ptr;
                    duty_next = ramp;
                    ptr_next  = ptr_inc;
                    // The ramp moves once per full pass over the channels.
                    if (ptr == LAST_CH) begin
                        if (!dir_down) begin
                            if (ramp_up > DUTY_MAX_X) begin
                                ramp_next = '1;
                                dir_next  = 1'b1;
                            end else begin
                                ramp_next = ramp_up[DUTY_W-1:0];
                            end
                        end else begin
                            if ({1'b0, ramp} >= STEP_X) begin
                                ramp_next = ramp - STEP_D;
                            end else begin
                                ramp_next = '0;
                                dir_next  = 1'b0;
                            end
                        end
                    end
                end else begin
                    tick_next = tick - TICK_W'(1);
                end
            end
            default: begin
                state_next = MODE_STEP;
            end
        endcase

        if (mode_press) begin
            case (state)
                MODE_MANUAL: state_next = MODE_STEP;
                MODE_STEP: begin
                    state_next = MODE_SWEEP;
                    tick_next  = TICK_LOAD;
                    ptr_next   = '0;
                    ramp_next  = '0;
                    dir_next   = 1'b0;
                end
                MODE_SWEEP:  state_next = MODE_MANUAL;
                default:     state_next = MODE_STEP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            ch_sel   <= '0;
            duty_in  <= '0;
            ptr      <= '0;
            ramp     <= '0;
            dir_down <= 1'b0;
            tick     <= TICK_LOAD;
        end else begin
            we       <= we_next;
            ch_sel   <= ch_next;
            duty_in  <= duty_next;
            ptr      <= ptr_next;
            ramp     <= ramp_next;
            dir_down <= dir_next;
            tick     <= tick_next;
        end
    end

    // Every write, from any mode, refreshes the shadow of its channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else if (we_next) begin
            shadow[ch_next] <= duty_next;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;

    localparam int NUM_CH = 4;
    localparam int STEP   = 32;
    localparam int DEB    = 4;
    localparam int SDIV   = 16;
    localparam int NRAMP  = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_step;
    logic [1:0] man_ch;
    logic [7:0] man_val;
    logic       man_wr;
    logic       we;
    logic [1:0] ch_sel;
    logic [7:0] duty_in;
    logic [1:0] mode;

    logic [2:0] man_ch5;
    logic       we5;
    logic [2:0] ch_sel5;
    logic [7:0] duty_in5;
    logic [1:0] mode5;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(
        .NUM_CH(NUM_CH), .DUTY_W(8), .STEP(STEP), .DEB_CYCLES(DEB), .SWEEP_DIV(SDIV)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_step(btn_step),
        .man_ch(man_ch), .man_val(man_val), .man_wr(man_wr),
        .we(we), .ch_sel(ch_sel), .duty_in(duty_in), .mode(mode)
    );

    // Non-power-of-two bank, used to reach out-of-range manual channels.
    pwm_duty_sequencer #(
        .NUM_CH(5), .DUTY_W(8), .STEP(STEP), .DEB_CYCLES(DEB), .SWEEP_DIV(SDIV)
    ) u_dut5 (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_step(btn_step),
        .man_ch(man_ch5), .man_val(man_val), .man_wr(man_wr),
        .we(we5), .ch_sel(ch_sel5), .duty_in(duty_in5), .mode(mode5)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int last_ch = 0;
    int last_duty = 0;

    // Reference model state
    int          m_mode, m_we, m_ch, m_duty;
    int          m_shadow [NUM_CH];
    int          sw_cycles, sw_writes;
    logic [15:0] h_mode, h_step;
    bit          deb_m, deb_s, pend_m, pend_s;

    typedef struct {
        logic [1:0] ch;
        logic [2:0] ch5;
        logic [7:0] val;
        logic       wr;
        logic       exp_we;
        logic [1:0] exp_ch;
        logic [7:0] exp_duty;
        logic       exp_we5;
    } vec_t;

    vec_t vecs [8];
    int   ramp_tab [NRAMP];
    int   step_ch_tab [7];
    int   step_duty_tab [7];

    // Triangle ramp value for sweep round r, straight from the ramp rules.
    function automatic int tri_ramp(int r);
        int v = 0;
        bit down = 1'b0;
        for (int i = 0; i < r; i++) begin
            if (!down) begin
                if (v + STEP <= 255) v = v + STEP;
                else begin v = 255; down = 1'b1; end
            end else begin
                if (v >= STEP) v = v - STEP;
                else begin v = 0; down = 1'b0; end
            end
        end
        return v;
    endfunction

    // h[0] is the raw level sampled at this edge; the debouncer sees it two
    // edges later. A flip needs the last DEB seen samples all to disagree.
    function automatic bit flips(logic [15:0] h, bit lvl);
        for (int j = 0; j < DEB; j++) begin
            if (h[2+j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic reset_model();
        m_mode = 1; m_we = 0; m_ch = 0; m_duty = 0;
        for (int i = 0; i < NUM_CH; i++) m_shadow[i] = 0;
        sw_cycles = 0; sw_writes = 0;
        h_mode = '0; h_step = '0;
        deb_m = 1'b0; deb_s = 1'b0; pend_m = 1'b0; pend_s = 1'b0;
    endtask

    task automatic mwrite(int c, int v);
        m_we = 1; m_ch = c; m_duty = v; m_shadow[c] = v;
    endtask

    task automatic model_edge();
        int c;
        if (rst) begin
            reset_model();
        end else begin
            m_we = 0;
            case (m_mode)
                0: if (man_wr && int'(man_ch) < NUM_CH) mwrite(int'(man_ch), int'(man_val));
                1: if (pend_s) begin
                    c = (m_ch + 1) % NUM_CH;
                    mwrite(c, (m_shadow[c] + STEP) % 256);
                end
                default: begin
                    sw_cycles++;
                    if (sw_cycles % SDIV == 0) begin
                        mwrite(sw_writes % NUM_CH, tri_ramp(sw_writes / NUM_CH));
                        sw_writes++;
                    end
                end
            endcase
            if (pend_m) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 2) begin sw_cycles = 0; sw_writes = 0; end
            end
            h_mode = {h_mode[14:0], btn_mode};
            h_step = {h_step[14:0], btn_step};
            pend_m = 1'b0;
            pend_s = 1'b0;
            if (flips(h_mode, deb_m)) begin deb_m = ~deb_m; pend_m = deb_m; end
            if (flips(h_step, deb_s)) begin deb_s = ~deb_s; pend_s = deb_s; end
        end
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        checks++;
        if (we !== 1'(m_we) || ch_sel !== 2'(m_ch) || duty_in !== 8'(m_duty) || mode !== 2'(m_mode)) begin
            errors++;
            $display("FAIL model cyc %0d: got we=%0b ch=%0d duty=%0d mode=%0d want we=%0d ch=%0d duty=%0d mode=%0d",
                     cyc, we, ch_sel, duty_in, mode, m_we, m_ch, m_duty, m_mode);
        end
        if (we) begin
            we_cnt++;
            last_ch = int'(ch_sel);
            last_duty = int'(duty_in);
        end
    endtask

    task automatic press(bit which, int hold, int rel);
        if (which) btn_step = 1'b1; else btn_mode = 1'b1;
        repeat (hold) cycle();
        if (which) btn_step = 1'b0; else btn_mode = 1'b0;
        repeat (rel) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, n, prev;

        vecs[0] = '{2'd2, 3'd2, 8'd200, 1'b1, 1'b1, 2'd2, 8'd200, 1'b1};
        vecs[1] = '{2'd3, 3'd7, 8'd77,  1'b0, 1'b0, 2'd2, 8'd200, 1'b0};
        vecs[2] = '{2'd3, 3'd7, 8'd99,  1'b1, 1'b1, 2'd3, 8'd99,  1'b0};
        vecs[3] = '{2'd0, 3'd5, 8'd10,  1'b1, 1'b1, 2'd0, 8'd10,  1'b0};
        vecs[4] = '{2'd1, 3'd4, 8'd255, 1'b1, 1'b1, 2'd1, 8'd255, 1'b1};
        vecs[5] = '{2'd2, 3'd0, 8'd0,   1'b0, 1'b0, 2'd1, 8'd255, 1'b0};
        vecs[6] = '{2'd3, 3'd0, 8'd5,   1'b1, 1'b1, 2'd3, 8'd5,   1'b1};
        vecs[7] = '{2'd0, 3'd0, 8'd0,   1'b0, 1'b0, 2'd3, 8'd5,   1'b0};
        ramp_tab = '{0, 32, 64, 96, 128, 160, 192, 224, 255,
                     223, 191, 159, 127, 95, 63, 31, 0, 32};
        step_ch_tab   = '{0, 1, 2, 3, 0, 1, 2};
        step_duty_tab = '{42, 31, 232, 37, 74, 63, 8};

        rst = 1'b1; btn_mode = 1'b0; btn_step = 1'b0;
        man_ch = '0; man_ch5 = '0; man_val = '0; man_wr = 1'b0;
        reset_model();
        repeat (3) cycle();
        chk("reset we", int'(we), 0);
        chk("reset ch_sel", int'(ch_sel), 0);
        chk("reset duty", int'(duty_in), 0);
        chk("reset mode", int'(mode), 1);
        rst = 1'b0;
        repeat (2) cycle();

        // Step presses, first one with a bounce at the start.
        w0 = we_cnt;
        btn_step = 1'b1; cycle();
        btn_step = 1'b0; cycle();
        press(1'b1, 10, 8);
        chk("step1 pulses", we_cnt - w0, 1);
        chk("step1 ch", last_ch, 1);
        chk("step1 duty", last_duty, 32);
        for (int p = 0; p < 4; p++) begin
            w0 = we_cnt;
            press(1'b1, 6, 8);
            chk("stepN pulses", we_cnt - w0, 1);
            chk("stepN ch", last_ch, (p + 2) % 4);
            chk("stepN duty", last_duty, (p == 3) ? 64 : 32);
        end

        // Short glitches on the mode button are rejected.
        w0 = we_cnt;
        for (int g = 1; g < DEB; g++) begin
            btn_mode = 1'b1; repeat (g) cycle();
            btn_mode = 1'b0; repeat (6) cycle();
        end
        chk("glitch mode", int'(mode), 1);
        chk("glitch pulses", we_cnt - w0, 0);
        press(1'b0, 6, 8);
        chk("mode to sweep", int'(mode), 2);
        press(1'b0, 6, 8);
        chk("mode to manual", int'(mode), 0);

        // Manual writes, table driven.
        for (int i = 0; i < 8; i++) begin
            man_ch = vecs[i].ch; man_ch5 = vecs[i].ch5;
            man_val = vecs[i].val; man_wr = vecs[i].wr;
            cycle();
            man_wr = 1'b0;
            chk("tab we", int'(we), int'(vecs[i].exp_we));
            chk("tab ch", int'(ch_sel), int'(vecs[i].exp_ch));
            chk("tab duty", int'(duty_in), int'(vecs[i].exp_duty));
            chk("tab we5", int'(we5), int'(vecs[i].exp_we5));
            chk("tab mode5", int'(mode5), 0);
            if (vecs[i].exp_we5) begin
                chk("tab ch5", int'(ch_sel5), int'(vecs[i].ch5));
                chk("tab duty5", int'(duty_in5), int'(vecs[i].val));
            end
        end
        man_ch5 = '0;

        w0 = we_cnt;
        press(1'b1, 6, 8);
        chk("manual ignores step", we_cnt - w0, 0);
        press(1'b0, 6, 8);
        chk("mode to step", int'(mode), 1);
        for (int p = 0; p < 7; p++) begin
            w0 = we_cnt;
            press(1'b1, 6, 8);
            chk("rmw pulses", we_cnt - w0, 1);
            chk("rmw ch", last_ch, step_ch_tab[p]);
            chk("rmw duty", last_duty, step_duty_tab[p]);
        end

        // Back to MANUAL, then man_wr coincident with the mode press event.
        press(1'b0, 6, 8);
        press(1'b0, 6, 8);
        chk("mode manual again", int'(mode), 0);
        btn_mode = 1'b1;
        repeat (6) cycle();
        chk("pre-event mode", int'(mode), 0);
        man_ch = 2'd1; man_val = 8'd123; man_wr = 1'b1;
        cycle();
        man_wr = 1'b0;
        chk("coinc we", int'(we), 1);
        chk("coinc ch", int'(ch_sel), 1);
        chk("coinc duty", int'(duty_in), 123);
        chk("coinc mode", int'(mode), 1);
        man_ch = 2'd2; man_val = 8'd50; man_wr = 1'b1;
        cycle();
        man_wr = 1'b0;
        chk("step ignores man_wr", int'(we), 0);
        btn_mode = 1'b0;
        repeat (8) cycle();

        // Sweep: ramp rounds and write spacing.
        press(1'b0, 6, 8);
        chk("sweep mode", int'(mode), 2);
        n = 0; prev = -1;
        for (int i = 0; i < NRAMP * NUM_CH * SDIV + 40 && n < NRAMP * NUM_CH; i++) begin
            cycle();
            if (we) begin
                chk("sweep ch", int'(ch_sel), n % NUM_CH);
                chk("sweep duty", int'(duty_in), ramp_tab[n / NUM_CH]);
                if (prev >= 0) chk("sweep gap", cyc - prev, SDIV);
                prev = cyc;
                n++;
            end
        end
        chk("sweep writes", n, NRAMP * NUM_CH);

        // Reset on the cycle a sweep tick is due.
        repeat (SDIV - 1) cycle();
        rst = 1'b1;
        #1;
        chk("async rst we", int'(we), 0);
        chk("async rst ch", int'(ch_sel), 0);
        chk("async rst duty", int'(duty_in), 0);
        chk("async rst mode", int'(mode), 1);
        cycle();
        chk("rst tick we", int'(we), 0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        w0 = we_cnt;
        press(1'b1, 6, 8);
        chk("post rst pulses", we_cnt - w0, 1);
        chk("post rst ch", last_ch, 1);
        chk("post rst duty", last_duty, 32);

        // Random stimulus against the reference model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 4) == 0) btn_step = ~btn_step;
            man_wr  = ($urandom_range(0, 3) == 0);
            man_ch  = 2'($urandom_range(0, 3));
            man_val = 8'($urandom);
            rst     = ($urandom_range(0, 599) == 0);
            cycle();
        end
        rst = 1'b0; man_wr = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
